// File: rtl/cosim_commit_collector.sv
// Collects one retired instruction's register writes into a keyed record and queues sealed records for the cosim checker.
// Latency: a record accepted at retire in cycle N is visible on the rec_* outputs in cycle N+1.
// Backpressure: retire_ready_o drops while the record FIFO is full; writes keep merging into staging until the retire is accepted.
module cosim_commit_collector #(
    parameter int DEPTH      = 4,
    parameter int MAX_WRITES = 16,
    parameter int XREG_W     = 64,
    parameter int FREG_W     = 64,
    parameter int KEY_W      = 16,
    parameter int CNT_W      = $clog2(MAX_WRITES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [KEY_W-1:0]  wr_key_i,
    input  logic [FREG_W-1:0] wr_value_i,
    input  logic              retire_valid_i,
    input  logic [XREG_W-1:0] retire_pc_i,
    input  logic [1:0]        retire_priv_i,
    output logic              retire_ready_o,
    output logic              rec_valid_o,
    input  logic              rec_ready_i,
    output logic [XREG_W-1:0] rec_pc_o,
    output logic [1:0]        rec_priv_o,
    output logic [CNT_W-1:0]  rec_count_o,
    input  logic [CNT_W-1:0]  rec_idx_i,
    output logic [KEY_W-1:0]  rec_key_o,
    output logic [FREG_W-1:0] rec_value_o,
    output logic              overflow_o
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_WRITES);

    // ------------------------------------------------------------------
    // Staging record: the writes of the instruction currently in flight
    // ------------------------------------------------------------------
    logic [KEY_W-1:0]      r_stg_key [MAX_WRITES];
    logic [FREG_W-1:0]     r_stg_val [MAX_WRITES];
    logic [CNT_W-1:0]      r_stg_cnt;
    logic                  r_overflow;

    logic [MAX_WRITES-1:0] w_hit_vec;
    logic                  w_hit;
    logic                  w_append;
    logic                  w_drop;
    logic [KEY_W-1:0]      w_nxt_key [MAX_WRITES];
    logic [FREG_W-1:0]     w_nxt_val [MAX_WRITES];
    logic [CNT_W-1:0]      w_nxt_cnt;

    // ------------------------------------------------------------------
    // Record FIFO: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [KEY_W-1:0]      r_fifo_key [DEPTH][MAX_WRITES];
    logic [FREG_W-1:0]     r_fifo_val [DEPTH][MAX_WRITES];
    logic [XREG_W-1:0]     r_fifo_pc  [DEPTH];
    logic [1:0]            r_fifo_priv[DEPTH];
    logic [CNT_W-1:0]      r_fifo_cnt [DEPTH];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_pop;
    logic [AW-1:0]         w_wr_idx;
    logic [AW-1:0]         w_head;
    logic [CNT_W-1:0]      w_head_cnt;

    // Full-width key match against the occupied staging slots only
    always_comb begin
        w_hit_vec = '0;
        for (int i = 0; i < MAX_WRITES; i++) begin
            w_hit_vec[i] = (CNT_W'(i) < r_stg_cnt) && (r_stg_key[i] == wr_key_i);
        end
    end

    assign w_hit     = |w_hit_vec;
    assign w_append  = wr_valid_i && !w_hit && (r_stg_cnt != FULL_CNT);
    assign w_drop    = wr_valid_i && !w_hit && (r_stg_cnt == FULL_CNT);
    assign w_nxt_cnt = w_append ? (r_stg_cnt + CNT_W'(1)) : r_stg_cnt;

    // Staging contents including this cycle's write; this is also what a retire seals
    always_comb begin
        for (int i = 0; i < MAX_WRITES; i++) begin
            w_nxt_key[i] = r_stg_key[i];
            w_nxt_val[i] = r_stg_val[i];
            if (wr_valid_i && w_hit_vec[i]) begin
                w_nxt_val[i] = wr_value_i;
            end
            if (w_append && (CNT_W'(i) == r_stg_cnt)) begin
                w_nxt_key[i] = wr_key_i;
                w_nxt_val[i] = wr_value_i;
            end
        end
    end

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_head   = r_rd_ptr[AW-1:0];

    // Ready depends only on the registered pointers, never on rec_ready_i
    assign retire_ready_o = !w_full;
    assign rec_valid_o    = !w_empty;
    assign w_accept       = retire_valid_i && retire_ready_o;
    assign w_pop          = rec_valid_o && rec_ready_i;
    assign overflow_o     = r_overflow;

    // Staging payload; slots past r_stg_cnt are don't-care, so no reset is needed
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_WRITES; i++) begin
            r_stg_key[i] <= w_nxt_key[i];
            r_stg_val[i] <= w_nxt_val[i];
        end
    end

    // Control state: staging count, sticky overflow and FIFO pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stg_cnt  <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_stg_cnt <= w_accept ? '0 : w_nxt_cnt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Seal the staging record plus retire info into the FIFO tail
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            for (int i = 0; i < MAX_WRITES; i++) begin
                r_fifo_key[w_wr_idx][i] <= w_nxt_key[i];
                r_fifo_val[w_wr_idx][i] <= w_nxt_val[i];
            end
            r_fifo_pc[w_wr_idx]   <= retire_pc_i;
            r_fifo_priv[w_wr_idx] <= retire_priv_i;
            r_fifo_cnt[w_wr_idx]  <= w_nxt_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Head record read port; everything masks to zero when nothing is valid
    // ------------------------------------------------------------------
    assign w_head_cnt  = r_fifo_cnt[w_head];
    assign rec_count_o = rec_valid_o ? w_head_cnt         : '0;
    assign rec_pc_o    = rec_valid_o ? r_fifo_pc[w_head]   : '0;
    assign rec_priv_o  = rec_valid_o ? r_fifo_priv[w_head] : '0;

    // Indexed entry select; indices at or beyond the entry count read zero
    always_comb begin
        rec_key_o   = '0;
        rec_value_o = '0;
        if (rec_valid_o && (rec_idx_i < w_head_cnt)) begin
            for (int i = 0; i < MAX_WRITES; i++) begin
                if (rec_idx_i == CNT_W'(i)) begin
                    rec_key_o   = r_fifo_key[w_head][i];
                    rec_value_o = r_fifo_val[w_head][i];
                end
            end
        end
    end

endmodule

// File: tb/tb_cosim_commit_collector.sv
// Self-checking bench for cosim_commit_collector.
// A queue-based reference model predicts every popped record and the sticky overflow flag.
// Directed scenarios plus a randomized mix of writes, held retires and pops.
module tb_cosim_commit_collector;

    localparam int DEPTH = 4;
    localparam int MW    = 16;

    logic        clk_i          = 1'b0;
    logic        rst_i          = 1'b1;
    logic        wr_valid_i     = 1'b0;
    logic [15:0] wr_key_i       = '0;
    logic [63:0] wr_value_i     = '0;
    logic        retire_valid_i = 1'b0;
    logic [63:0] retire_pc_i    = '0;
    logic [1:0]  retire_priv_i  = '0;
    logic        rec_ready_i    = 1'b0;
    logic [4:0]  rec_idx_i      = '0;
    logic        retire_ready_o;
    logic        rec_valid_o;
    logic [63:0] rec_pc_o;
    logic [1:0]  rec_priv_o;
    logic [4:0]  rec_count_o;
    logic [15:0] rec_key_o;
    logic [63:0] rec_value_o;
    logic        overflow_o;

    cosim_commit_collector #(
        .DEPTH(DEPTH), .MAX_WRITES(MW), .XREG_W(64), .FREG_W(64), .KEY_W(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wr_valid_i(wr_valid_i), .wr_key_i(wr_key_i), .wr_value_i(wr_value_i),
        .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .retire_priv_i(retire_priv_i), .retire_ready_o(retire_ready_o),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_pc_o(rec_pc_o), .rec_priv_o(rec_priv_o), .rec_count_o(rec_count_o),
        .rec_idx_i(rec_idx_i), .rec_key_o(rec_key_o), .rec_value_o(rec_value_o),
        .overflow_o(overflow_o)
    );

    always #20 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0]       pc;
        logic [1:0]        priv;
        logic [4:0]        cnt;
        logic [15:0][15:0] key;
        logic [15:0][63:0] val;
    } rec_t;

    rec_t              mq[$];
    rec_t              exp_q[$];
    rec_t              act_q[$];
    logic [15:0][15:0] mkey;
    logic [15:0][63:0] mval;
    int                mcnt;
    logic              movf;
    logic              m_acc;
    logic              last_ready;
    logic              last_valid;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic model_reset();
        mq.delete(); exp_q.delete(); act_q.delete();
        mkey = '0; mval = '0; mcnt = 0; movf = 1'b0; m_acc = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, capture any popped head record,
    // then advance the reference model to what the next rising edge should do.
    task automatic step(input logic wv, input logic [15:0] wk, input logic [63:0] wd,
                        input logic rv, input logic [63:0] pc, input logic [1:0] pv,
                        input logic rr);
        rec_t r;
        int   hit;
        logic pop;
        @(negedge clk_i);
        wr_valid_i = wv; wr_key_i = wk; wr_value_i = wd;
        retire_valid_i = rv; retire_pc_i = pc; retire_priv_i = pv;
        rec_ready_i = rr;
        #1;
        last_ready = retire_ready_o;
        last_valid = rec_valid_o;
        if (rr && rec_valid_o) begin
            r = '0;
            r.pc = rec_pc_o; r.priv = rec_priv_o; r.cnt = rec_count_o;
            for (int i = 0; i < MW; i++) begin
                rec_idx_i = 5'(i);
                #1;
                r.key[i] = rec_key_o;
                r.val[i] = rec_value_o;
            end
            act_q.push_back(r);
        end
        m_acc = rv && (mq.size() != DEPTH);
        pop   = rr && (mq.size() != 0);
        if (wv) begin
            hit = -1;
            for (int i = 0; i < mcnt; i++) if (mkey[i] == wk) hit = i;
            if (hit >= 0) mval[hit] = wd;
            else if (mcnt < MW) begin mkey[mcnt] = wk; mval[mcnt] = wd; mcnt++; end
            else movf = 1'b1;
        end
        if (pop) exp_q.push_back(mq.pop_front());
        if (m_acc) begin
            r = '0;
            r.pc = pc; r.priv = pv; r.cnt = 5'(mcnt); r.key = mkey; r.val = mval;
            mq.push_back(r);
            mkey = '0; mval = '0; mcnt = 0;
        end
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) step(1'b0, 16'h0, 64'h0, 1'b0, 64'h0, 2'd0, rr);
    endtask

    // Let the pending rising edge happen, then park the inputs
    task automatic settle();
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0; retire_valid_i = 1'b0; rec_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", rec_valid_o); end
        n_checks++; if (rec_count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", rec_count_o); end
        n_checks++; if (rec_pc_o !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", rec_pc_o); end
        n_checks++; if (rec_priv_o !== 2'd0) begin n_fail++; $display("FAIL reset_priv: got %0d want 0", rec_priv_o); end
        n_checks++; if (rec_key_o !== 16'h0 || rec_value_o !== 64'h0) begin n_fail++; $display("FAIL reset_entry: got key=%h val=%h want 0", rec_key_o, rec_value_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_checks++; if (retire_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", retire_ready_o); end
        model_reset();
    endtask

    task automatic test_three_writes();
        logic [15:0] ek [4];
        logic [63:0] ev [4];
        ek = '{16'h0010, 16'h0020, 16'h0031, 16'h0000};
        ev = '{64'h11, 64'h22, 64'h33, 64'h0};
        step(1'b1, 16'h0010, 64'h11, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0020, 64'h22, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0031, 64'h33, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, 64'h8000_0000, 2'd3, 1'b0);
        n_checks++; if (last_valid !== 1'b0) begin n_fail++; $display("FAIL tw_valid_before: got %0b want 0", last_valid); end
        settle();
        n_checks++; if (rec_valid_o !== 1'b1) begin n_fail++; $display("FAIL tw_valid_next: got %0b want 1", rec_valid_o); end
        n_checks++; if (rec_count_o !== 5'd3) begin n_fail++; $display("FAIL tw_count: got %0d want 3", rec_count_o); end
        n_checks++; if (rec_pc_o !== 64'h8000_0000 || rec_priv_o !== 2'd3) begin n_fail++; $display("FAIL tw_pc: got %h/%0d want 80000000/3", rec_pc_o, rec_priv_o); end
        for (int i = 0; i < 4; i++) begin
            rec_idx_i = 5'(i);
            #1;
            n_checks++;
            if (rec_key_o !== ek[i] || rec_value_o !== ev[i]) begin
                n_fail++; $display("FAIL tw_idx%0d: got %h=%h want %h=%h", i, rec_key_o, rec_value_o, ek[i], ev[i]);
            end
        end
        idle(1, 1'b1);
        settle();
        n_checks++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL tw_valid_after_pop: got %0b want 0", rec_valid_o); end
        n_checks++;
        if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tw_pops: got %0d want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tw_rec%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, act_q[i].pc, act_q[i].cnt, exp_q[i].pc, exp_q[i].cnt); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_merge();
        step(1'b1, 16'h0050, 64'hA, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0050, 64'hB, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0060, 64'hC, 1'b1, 64'h100, 2'd1, 1'b0);
        settle();
        n_checks++; if (rec_count_o !== 5'd2) begin n_fail++; $display("FAIL mg_count: got %0d want 2", rec_count_o); end
        rec_idx_i = 5'd0; #1;
        n_checks++; if (rec_key_o !== 16'h0050 || rec_value_o !== 64'hB) begin n_fail++; $display("FAIL mg_idx0: got %h=%h want 0050=b", rec_key_o, rec_value_o); end
        rec_idx_i = 5'd1; #1;
        n_checks++; if (rec_key_o !== 16'h0060 || rec_value_o !== 64'hC) begin n_fail++; $display("FAIL mg_idx1: got %h=%h want 0060=c", rec_key_o, rec_value_o); end
        idle(1, 1'b1);
        n_checks++;
        if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mg_pops: got %0d want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mg_rec%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, act_q[i].pc, act_q[i].cnt, exp_q[i].pc, exp_q[i].cnt); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [63:0] pc4;
        pc4 = 64'h210;
        for (int k = 0; k < 4; k++)
            step(1'b1, {12'(k + 1), 4'h0}, 64'($urandom), 1'b1, 64'h200 + 64'(4 * k), 2'd1, 1'b0);
        settle();
        n_checks++; if (retire_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0", retire_ready_o); end
        step(1'b1, 16'h0070, 64'h1, 1'b1, pc4, 2'd1, 1'b0);
        n_checks++; if (last_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall1_ready: got %0b want 0", last_ready); end
        step(1'b1, 16'h0080, 64'h2, 1'b1, pc4, 2'd1, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, pc4, 2'd1, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, pc4, 2'd1, 1'b1);
        n_checks++; if (last_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pop_cycle_ready: got %0b want 0", last_ready); end
        step(1'b0, 16'h0, 64'h0, 1'b1, pc4, 2'd1, 1'b0);
        n_checks++; if (last_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_pop_ready: got %0b want 1", last_ready); end
        idle(5, 1'b1);
        n_checks++;
        if (act_q.size() != 5 || exp_q.size() != 5) begin n_fail++; $display("FAIL bp_pops: got %0d want 5 (model %0d)", act_q.size(), exp_q.size()); end
        else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (act_q[i] !== exp_q[i] || act_q[i].pc !== 64'h200 + 64'(4 * i)) begin n_fail++; $display("FAIL bp_rec%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, act_q[i].pc, act_q[i].cnt, exp_q[i].pc, exp_q[i].cnt); end
            end
            n_checks++;
            if (act_q[4].cnt !== 5'd2 || act_q[4].key[0] !== 16'h0070 || act_q[4].key[1] !== 16'h0080) begin n_fail++; $display("FAIL bp_rec4_entries: got cnt=%0d keys=%h,%h want 2 0070,0080", act_q[4].cnt, act_q[4].key[0], act_q[4].key[1]); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 16; k++)
            step(1'b1, {12'(k + 1), 4'h0}, 64'($urandom), 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0010, 64'hBEEF, 1'b0, 64'h0, 2'd0, 1'b0);
        settle();
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ov_merge_full: got %0b want 0", overflow_o); end
        step(1'b1, {12'd17, 4'h0}, 64'h17, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b0, 16'h0, 64'h0, 1'b1, 64'h300, 2'd2, 1'b0);
        settle();
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ov_set: got %0b want 1", overflow_o); end
        n_checks++; if (rec_count_o !== 5'd16) begin n_fail++; $display("FAIL ov_count: got %0d want 16", rec_count_o); end
        rec_idx_i = 5'd0; #1;
        n_checks++; if (rec_value_o !== 64'hBEEF) begin n_fail++; $display("FAIL ov_merged_val: got %h want beef", rec_value_o); end
        rec_idx_i = 5'd16; #1;
        n_checks++; if (rec_key_o !== 16'h0) begin n_fail++; $display("FAIL ov_idx16: got %h want 0", rec_key_o); end
        idle(1, 1'b1);
        step(1'b1, 16'h0010, 64'h5, 1'b1, 64'h304, 2'd0, 1'b0);
        idle(2, 1'b1);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ov_sticky: got %0b want 1", overflow_o); end
        n_checks++;
        if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ov_pops: got %0d want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ov_rec%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, act_q[i].pc, act_q[i].cnt, exp_q[i].pc, exp_q[i].cnt); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 16'h0090, 64'($urandom), 1'b1, 64'h1000 + 64'(k), 2'd0, 1'b1);
            n_checks++; if (last_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %0b want 1", k, last_ready); end
        end
        idle(1, 1'b1);
        n_checks++;
        if (act_q.size() != 10 || exp_q.size() != 10) begin n_fail++; $display("FAIL b2b_pops: got %0d want 10 (model %0d)", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i] || act_q[i].pc !== 64'h1000 + 64'(i)) begin n_fail++; $display("FAIL b2b_rec%0d: got pc=%h val=%h want pc=%h val=%h", i, act_q[i].pc, act_q[i].val[0], exp_q[i].pc, exp_q[i].val[0]); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic        pend;
        logic [63:0] pc;
        logic [1:0]  pv;
        logic        rv;
        pend = 1'b0; pc = '0; pv = '0;
        for (int c = 0; c < 300; c++) begin
            rv = pend || ($urandom_range(0, 3) == 0);
            if (!pend) begin pc = {32'($urandom), 32'($urandom)}; pv = 2'($urandom); end
            step(1'($urandom), {12'($urandom_range(1, 6)), 4'($urandom_range(0, 1))},
                 {32'($urandom), 32'($urandom)}, rv, pc, pv, ($urandom_range(0, 2) == 0));
            pend = rv && !m_acc;
        end
        for (int c = 0; c < 8 && pend; c++) begin
            step(1'b0, 16'h0, 64'h0, 1'b1, pc, pv, 1'b1);
            pend = !m_acc;
        end
        idle(DEPTH + 2, 1'b1);
        n_checks++; if (overflow_o !== movf) begin n_fail++; $display("FAIL rnd_overflow: got %0b want %0b", overflow_o, movf); end
        n_checks++;
        if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_pops: got %0d want %0d", act_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_rec%0d: got pc=%h cnt=%0d want pc=%h cnt=%0d", i, act_q[i].pc, act_q[i].cnt, exp_q[i].pc, exp_q[i].cnt); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        step(1'b1, 16'h0110, 64'h1, 1'b1, 64'h500, 2'd0, 1'b0);
        step(1'b1, 16'h0120, 64'h2, 1'b1, 64'h504, 2'd0, 1'b0);
        step(1'b1, 16'h0130, 64'h3, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0131, 64'h4, 1'b0, 64'h0, 2'd0, 1'b0);
        step(1'b1, 16'h0132, 64'h5, 1'b0, 64'h0, 2'd0, 1'b0);
        @(negedge clk_i);
        wr_valid_i = 1'b0; retire_valid_i = 1'b0; rec_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_checks++; if (rec_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0b want 0", rec_valid_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rm_overflow: got %0b want 0", overflow_o); end
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        step(1'b1, 16'h0140, 64'h99, 1'b1, 64'h400, 2'd2, 1'b0);
        idle(1, 1'b1);
        n_checks++;
        if (act_q.size() != 1 || exp_q.size() != 1) begin n_fail++; $display("FAIL rm_pops: got %0d want 1 (model %0d)", act_q.size(), exp_q.size()); end
        else begin
            n_checks++;
            if (act_q[0] !== exp_q[0] || act_q[0].cnt !== 5'd1 || act_q[0].key[0] !== 16'h0140) begin n_fail++; $display("FAIL rm_rec: got pc=%h cnt=%0d key=%h want pc=400 cnt=1 key=0140", act_q[0].pc, act_q[0].cnt, act_q[0].key[0]); end
        end
        act_q.delete(); exp_q.delete();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_three_writes();
        test_merge();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
